// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants and receiver state encoding.
package uart_pkg;
  localparam int CLK_HZ = 50_000_000;
  localparam int BAUD = 115200;
  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = OVERSAMPLE / 2 - 1;
  typedef enum logic [2:0] {IDLE = 3'd0, START = 3'd1, DATA = 3'd2, STOP = 3'd3, BREAK = 3'd4} state_t;
endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: host-side ready/clear handshake of the UART receiver.
interface uart_rx_if #(parameter int DATA_BITS = 8);
  logic rdy_clr;
  logic rdy;
  logic [DATA_BITS-1:0] data;
  logic frame_err;
  logic overrun;
  modport master(input rdy_clr, output rdy, data, frame_err, overrun);
  modport slave(output rdy_clr, input rdy, data, frame_err, overrun);
endinterface

// File: rtl/uart_rx_sync_2ff.sv
// sync_2ff: two-flop synchronizer with a parameterised reset value.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);
  logic [1:0] sync_q;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) sync_q <= {2{RST_VAL}};
    else sync_q <= {sync_q[0], d_i};
  assign q_o = sync_q[1];
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampling UART receiver with ready/clear handshake and error flags.
module uart_rx #(
  parameter int DATA_BITS = 8,
  parameter int OVERSAMPLE = uart_pkg::OVERSAMPLE
) (
  input  logic clk_50m,
  input  logic rst_n,
  input  logic rx,
  input  logic clken,
  uart_rx_if.master host
);
  import uart_pkg::*;
  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [SW-1:0] MID = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] LAST = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
  logic rx_s;
  state_t state_q, state_d;
  logic [SW-1:0] sample_q, sample_d;
  logic [BW-1:0] bitidx_q, bitidx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d, data_q, data_d;
  logic rdy_q, rdy_d, ferr_q, ferr_d, ovr_q, ovr_d;
  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk_i (clk_50m),
    .rst_ni(rst_n),
    .d_i   (rx),
    .q_o   (rx_s)
  );
  always_ff @(posedge clk_50m or negedge rst_n)
    if (!rst_n) begin
      state_q  <= IDLE;
      sample_q <= '0;
      bitidx_q <= '0;
      shift_q  <= '0;
      data_q   <= '0;
      rdy_q    <= 1'b0;
      ferr_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sample_q <= sample_d;
      bitidx_q <= bitidx_d;
      shift_q  <= shift_d;
      data_q   <= data_d;
      rdy_q    <= rdy_d;
      ferr_q   <= ferr_d;
      ovr_q    <= ovr_d;
    end
  // A host clear applies every cycle; a frame completing in the same cycle overrides it.
  always_comb begin
    state_d  = state_q;
    sample_d = sample_q;
    bitidx_d = bitidx_q;
    shift_d  = shift_q;
    data_d   = data_q;
    rdy_d    = rdy_q & ~host.rdy_clr;
    ferr_d   = ferr_q & ~host.rdy_clr;
    ovr_d    = ovr_q & ~host.rdy_clr;
    if (clken)
      case (state_q)
        IDLE: if (!rx_s) begin
          state_d  = START;
          sample_d = '0;
        end
        START: if (sample_q == MID) begin
          state_d  = rx_s ? IDLE : DATA;
          sample_d = '0;
          bitidx_d = '0;
        end else sample_d = sample_q + SW'(1);
        DATA: if (sample_q == LAST) begin
          shift_d[bitidx_q] = rx_s;
          sample_d = '0;
          state_d  = (bitidx_q == LAST_BIT) ? STOP : DATA;
          bitidx_d = (bitidx_q == LAST_BIT) ? bitidx_q : bitidx_q + BW'(1);
        end else sample_d = sample_q + SW'(1);
        STOP: if (sample_q == LAST) begin
          sample_d = '0;
          state_d  = rx_s ? IDLE : BREAK;
          ferr_d   = ~rx_s;
          if (rx_s) begin
            data_d = shift_q;
            rdy_d  = 1'b1;
            ovr_d  = rdy_q & ~host.rdy_clr;
          end
        end else sample_d = sample_q + SW'(1);
        BREAK: if (rx_s) state_d = IDLE;
        default: state_d = IDLE;
      endcase
  end
  assign host.rdy       = rdy_q;
  assign host.data      = data_q;
  assign host.frame_err = ferr_q;
  assign host.overrun   = ovr_q;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed scenario tests for uart_rx with a 28-clk clken period.
`timescale 1ns/1ps
module tb_uart_rx;
  logic clk_50m = 1'b0;
  logic rst_n = 1'b0;
  logic rx = 1'b1;
  logic clken = 1'b0;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rises = 0;
  int rise_cyc = 0;
  int start_cyc = 0;
  logic rdy_prev = 1'b0;
  uart_rx_if #(.DATA_BITS(8)) host ();
  uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
    .clk_50m(clk_50m),
    .rst_n  (rst_n),
    .rx     (rx),
    .clken  (clken),
    .host   (host)
  );
  always #10 clk_50m = ~clk_50m;
  initial forever begin
    repeat (27) @(negedge clk_50m);
    clken = 1'b1;
    @(negedge clk_50m);
    clken = 1'b0;
  end
  always @(posedge clk_50m) cyc <= cyc + 1;
  always @(negedge clk_50m) begin
    rdy_prev <= host.rdy;
    if (host.rdy && !rdy_prev) begin
      rises <= rises + 1;
      rise_cyc <= cyc;
    end
  end
  initial begin
    #1_900_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end
  task automatic send_frame(input logic [7:0] b, input logic stop, input int stop_bits);
    @(negedge clk_50m);
    rx = 1'b0;
    start_cyc = cyc;
    repeat (448) @(negedge clk_50m);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (448) @(negedge clk_50m);
    end
    rx = stop;
    repeat (448 * stop_bits) @(negedge clk_50m);
    rx = 1'b1;
  endtask
  task automatic test_reset();
    host.rdy_clr = 1'b0;
    repeat (5) @(negedge clk_50m);
    checks += 4;
    if (host.rdy !== 1'b0) begin failures++; $display("FAIL reset_rdy: got %b expected 0", host.rdy); end
    if (host.data !== 8'h00) begin failures++; $display("FAIL reset_data: got %h expected 00", host.data); end
    if (host.frame_err !== 1'b0) begin failures++; $display("FAIL reset_ferr: got %b expected 0", host.frame_err); end
    if (host.overrun !== 1'b0) begin failures++; $display("FAIL reset_ovr: got %b expected 0", host.overrun); end
    rst_n = 1'b1;
    repeat (5) @(negedge clk_50m);
  endtask
  task automatic test_basic();
    int r0;
    int lat;
    r0 = rises;
    send_frame(8'hA5, 1'b1, 1);
    lat = rise_cyc - start_cyc;
    checks += 6;
    if (rises !== r0 + 1) begin failures++; $display("FAIL basic_rise_count: got %0d expected %0d", rises, r0 + 1); end
    if (lat < 4228 || lat > 4288) begin failures++; $display("FAIL basic_latency: got %0d expected 4228..4288", lat); end
    if (host.rdy !== 1'b1) begin failures++; $display("FAIL basic_rdy: got %b expected 1", host.rdy); end
    if (host.data !== 8'hA5) begin failures++; $display("FAIL basic_data: got %h expected a5", host.data); end
    if (host.frame_err !== 1'b0) begin failures++; $display("FAIL basic_ferr: got %b expected 0", host.frame_err); end
    if (host.overrun !== 1'b0) begin failures++; $display("FAIL basic_ovr: got %b expected 0", host.overrun); end
    @(negedge clk_50m);
    host.rdy_clr = 1'b1;
    @(negedge clk_50m);
    host.rdy_clr = 1'b0;
    checks++;
    if (host.rdy !== 1'b0) begin failures++; $display("FAIL basic_clr: got %b expected 0", host.rdy); end
  endtask
  task automatic test_glitch();
    int r0;
    r0 = rises;
    @(negedge clk_50m);
    rx = 1'b0;
    repeat (84) @(negedge clk_50m);
    rx = 1'b1;
    repeat (896) @(negedge clk_50m);
    checks += 2;
    if (host.rdy !== 1'b0) begin failures++; $display("FAIL glitch_rdy: got %b expected 0", host.rdy); end
    if (rises !== r0) begin failures++; $display("FAIL glitch_rises: got %0d expected %0d", rises, r0); end
    send_frame(8'h3C, 1'b1, 1);
    checks += 2;
    if (host.rdy !== 1'b1) begin failures++; $display("FAIL glitch_next_rdy: got %b expected 1", host.rdy); end
    if (host.data !== 8'h3C) begin failures++; $display("FAIL glitch_next_data: got %h expected 3c", host.data); end
    @(negedge clk_50m);
    host.rdy_clr = 1'b1;
    @(negedge clk_50m);
    host.rdy_clr = 1'b0;
  endtask
  task automatic test_frame_err();
    send_frame(8'h55, 1'b0, 2);
    checks += 3;
    if (host.frame_err !== 1'b1) begin failures++; $display("FAIL ferr_set: got %b expected 1", host.frame_err); end
    if (host.rdy !== 1'b0) begin failures++; $display("FAIL ferr_rdy: got %b expected 0", host.rdy); end
    if (host.data !== 8'h3C) begin failures++; $display("FAIL ferr_data: got %h expected 3c", host.data); end
    repeat (448) @(negedge clk_50m);
    send_frame(8'h0F, 1'b1, 1);
    checks += 3;
    if (host.data !== 8'h0F) begin failures++; $display("FAIL ferr_next_data: got %h expected 0f", host.data); end
    if (host.frame_err !== 1'b0) begin failures++; $display("FAIL ferr_next_ferr: got %b expected 0", host.frame_err); end
    if (host.rdy !== 1'b1) begin failures++; $display("FAIL ferr_next_rdy: got %b expected 1", host.rdy); end
    @(negedge clk_50m);
    host.rdy_clr = 1'b1;
    @(negedge clk_50m);
    host.rdy_clr = 1'b0;
  endtask
  task automatic test_overrun();
    send_frame(8'h11, 1'b1, 1);
    send_frame(8'h22, 1'b1, 1);
    checks += 3;
    if (host.data !== 8'h22) begin failures++; $display("FAIL ovr_data: got %h expected 22", host.data); end
    if (host.rdy !== 1'b1) begin failures++; $display("FAIL ovr_rdy: got %b expected 1", host.rdy); end
    if (host.overrun !== 1'b1) begin failures++; $display("FAIL ovr_flag: got %b expected 1", host.overrun); end
    @(negedge clk_50m);
    host.rdy_clr = 1'b1;
    @(negedge clk_50m);
    host.rdy_clr = 1'b0;
    checks += 2;
    if (host.overrun !== 1'b0) begin failures++; $display("FAIL ovr_clr_flag: got %b expected 0", host.overrun); end
    if (host.rdy !== 1'b0) begin failures++; $display("FAIL ovr_clr_rdy: got %b expected 0", host.rdy); end
  endtask
  task automatic test_simultaneous();
    int n;
    send_frame(8'h66, 1'b1, 1);
    n = 0;
    do begin
      @(posedge clk_50m);
      n++;
    end while (!clken && n < 60);
    checks++;
    if (!clken) begin failures++; $display("FAIL simul_clken_sync: got 0 expected 1"); end
    // Start edge lands right after a clken tick, so detection is 28 clk later and completion 152 ticks after that.
    fork
      send_frame(8'h99, 1'b1, 1);
      begin
        repeat (4283) @(posedge clk_50m);
        @(negedge clk_50m);
        host.rdy_clr = 1'b1;
        @(negedge clk_50m);
        host.rdy_clr = 1'b0;
      end
    join
    checks += 3;
    if (host.rdy !== 1'b1) begin failures++; $display("FAIL simul_rdy: got %b expected 1", host.rdy); end
    if (host.data !== 8'h99) begin failures++; $display("FAIL simul_data: got %h expected 99", host.data); end
    if (host.overrun !== 1'b0) begin failures++; $display("FAIL simul_ovr: got %b expected 0", host.overrun); end
  endtask
  task automatic test_reset_midframe();
    int r0;
    fork
      send_frame(8'hF0, 1'b1, 1);
      begin
        repeat (448 * 5 + 200) @(negedge clk_50m);
        rst_n = 1'b0;
        #1;
        checks += 4;
        if (host.rdy !== 1'b0) begin failures++; $display("FAIL rst_mid_rdy: got %b expected 0", host.rdy); end
        if (host.data !== 8'h00) begin failures++; $display("FAIL rst_mid_data: got %h expected 00", host.data); end
        if (host.frame_err !== 1'b0) begin failures++; $display("FAIL rst_mid_ferr: got %b expected 0", host.frame_err); end
        if (host.overrun !== 1'b0) begin failures++; $display("FAIL rst_mid_ovr: got %b expected 0", host.overrun); end
        repeat (100) @(negedge clk_50m);
        rst_n = 1'b1;
      end
    join
    repeat (448) @(negedge clk_50m);
    checks++;
    if (host.rdy !== 1'b0) begin failures++; $display("FAIL rst_mid_spurious: got %b expected 0", host.rdy); end
    r0 = rises;
    send_frame(8'h81, 1'b1, 1);
    checks += 3;
    if (host.data !== 8'h81) begin failures++; $display("FAIL rst_next_data: got %h expected 81", host.data); end
    if (host.rdy !== 1'b1) begin failures++; $display("FAIL rst_next_rdy: got %b expected 1", host.rdy); end
    if (rises !== r0 + 1) begin failures++; $display("FAIL rst_next_rises: got %0d expected %0d", rises, r0 + 1); end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_simultaneous();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
